uart_boot_loader: RTL and testbench

Sequencer that loads a program image from the UART receive FIFO into RAM through the memory write port, while holding the CPU in reset. It parses a framed byte stream: sync byte, word count, data words, XOR checksum. It writes each assembled 16-bit word to consecutive RAM addresses. On success it releases the CPU. If no host appears within the timeout, it also releases the CPU and runs the existing RAM contents.

---
 rtl/uart_boot_loader.sv | 205 ++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_boot_loader
// Brief    : Loads a framed program image (sync, 16-bit word count, data
//            words, XOR checksum) from the UART receive FIFO into RAM while
//            holding the CPU in reset. Releases the CPU on success or when
//            no host shows up before the boot timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_boot_loader #(
    parameter logic [15:0] BASE_ADDR      = 16'h0000,
    parameter int          MAX_WORDS      = 16384,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic        i_RX_Empty,
    input  logic [7:0]  i_RX_Byte,
    output logic        o_RX_Pop,
    output logic [15:0] o_Mem_Address,
    output logic [15:0] o_Mem_Data,
    output logic        o_Mem_Write_EN,
    output logic        o_CPU_Hold,
    output logic        o_Done,
    output logic        o_Error
);

    localparam int                   TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]          MAX_COUNT  = 17'(MAX_WORDS);

    typedef enum logic [3:0] {
        SYNC    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        CSUM    = 4'd6,
        DONE    = 4'd7,
        ERROR   = 4'd8
    } state_t;

    state_t               state;
    logic [15:0]          count;
    logic [15:0]          index;
    logic [7:0]           word_hi;
    logic [7:0]           checksum;
    logic [TIMER_W-1:0]   timer;
    logic                 gap;

    logic [15:0]          mem_address;
    logic [15:0]          mem_data;
    logic                 mem_write_en;
    logic                 cpu_hold;
    logic                 done;
    logic                 error;

    logic                 receiving;
    logic                 pop;
    logic                 timed_out;
    logic [15:0]          len_value;
    logic [15:0]          next_index;

    // Pop decision and helper values derived from the current state.
    always_comb begin
        receiving  = (state == SYNC)    || (state == LEN_HI)  ||
                     (state == LEN_LO)  || (state == DATA_HI) ||
                     (state == DATA_LO) || (state == CSUM);
        // The gap cycle after each pop gives the FIFO time to update its flag.
        pop        = receiving && !i_RX_Empty && !gap;
        timed_out  = receiving && !pop && (timer == TIMER_LAST);
        len_value  = {count[15:8], i_RX_Byte};
        next_index = index + 16'd1;
    end

    assign o_RX_Pop       = pop;
    assign o_Mem_Address  = mem_address;
    assign o_Mem_Data     = mem_data;
    assign o_Mem_Write_EN = mem_write_en;
    assign o_CPU_Hold     = cpu_hold;
    assign o_Done         = done;
    assign o_Error        = error;

    // Frame parser, idle timer and registered outputs.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state        <= SYNC;
            count        <= 16'd0;
            index        <= 16'd0;
            word_hi      <= 8'd0;
            checksum     <= 8'd0;
            timer        <= '0;
            gap          <= 1'b0;
            mem_address  <= BASE_ADDR;
            mem_data     <= 16'd0;
            mem_write_en <= 1'b0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            gap          <= pop;
            mem_write_en <= 1'b0;

            // Idle timer: cleared by any pop or any state change, counts
            // only while a receive state waits for a byte.
            if (!receiving || pop || timed_out) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            if (timed_out) begin
                // No host before the first sync byte: boot whatever RAM holds.
                if (state == SYNC) begin
                    state    <= DONE;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end else begin
                    state    <= ERROR;
                    error    <= 1'b1;
                end
            end else begin
                case (state)
                    SYNC: begin
                        if (pop && (i_RX_Byte == SYNC_BYTE)) begin
                            state    <= LEN_HI;
                            checksum <= 8'd0;
                            index    <= 16'd0;
                        end
                    end
                    LEN_HI: begin
                        if (pop) begin
                            count[15:8] <= i_RX_Byte;
                            state       <= LEN_LO;
                        end
                    end
                    LEN_LO: begin
                        if (pop) begin
                            count[7:0] <= i_RX_Byte;
                            if ({1'b0, len_value} > MAX_COUNT) begin
                                state <= ERROR;
                                error <= 1'b1;
                            end else if (len_value == 16'd0) begin
                                state <= CSUM;
                            end else begin
                                state <= DATA_HI;
                            end
                        end
                    end
                    DATA_HI: begin
                        if (pop) begin
                            word_hi  <= i_RX_Byte;
                            checksum <= checksum ^ i_RX_Byte;
                            state    <= DATA_LO;
                        end
                    end
                    DATA_LO: begin
                        if (pop) begin
                            checksum     <= checksum ^ i_RX_Byte;
                            state        <= WRITE;
                            // Strobe is registered so it is high exactly while in WRITE.
                            mem_write_en <= 1'b1;
                            mem_address  <= BASE_ADDR + index;
                            mem_data     <= {word_hi, i_RX_Byte};
                        end
                    end
                    WRITE: begin
                        index <= next_index;
                        if (next_index == count) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                    CSUM: begin
                        if (pop) begin
                            if (i_RX_Byte == checksum) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                state    <= ERROR;
                                error    <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    ERROR: begin
                        state <= ERROR;
                    end
                    default: begin
                        state <= ERROR;
                        error <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_boot_loader
// Brief    : Self-checking bench for uart_boot_loader. A queue models the
//            UART FIFO; a frame-level reference model predicts RAM writes
//            and the final outcome of each byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;

    localparam int          TO_CYCLES = 100;
    localparam int          MAXW      = 16384;
    localparam logic [15:0] BASE      = 16'h0000;
    localparam logic [7:0]  SYNC      = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_empty = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_pop;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_write_en;
    logic        cpu_hold;
    logic        done;
    logic        error;

    uart_boot_loader #(
        .BASE_ADDR      (BASE),
        .MAX_WORDS      (MAXW),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .i_CLK          (clk),
        .i_RESET        (rst),
        .i_RX_Empty     (rx_empty),
        .i_RX_Byte      (rx_byte),
        .o_RX_Pop       (rx_pop),
        .o_Mem_Address  (mem_address),
        .o_Mem_Data     (mem_data),
        .o_Mem_Write_EN (mem_write_en),
        .o_CPU_Hold     (cpu_hold),
        .o_Done         (done),
        .o_Error        (error)
    );

    always #5 clk = ~clk;

    logic [7:0]  fifo[$];
    logic [7:0]  frame[$];
    logic [31:0] obs_writes[$];
    logic [31:0] exp_writes[$];
    int          exp_outcome;   // 1 = done, 2 = error
    int          total_pops   = 0;
    int          consec_pops  = 0;
    int          both_flags   = 0;
    bit          prev_pop     = 1'b0;
    bit          stall_en     = 1'b0;
    int          n_checks     = 0;
    int          n_fail       = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drive();
        rx_empty = (fifo.size() == 0) || (stall_en && ($urandom_range(0, 2) == 0));
        rx_byte  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    // Advance one clock; called at the sample point (negedge + 1).
    task automatic step();
        bit p;
        p = rx_pop;
        if (mem_write_en) obs_writes.push_back({mem_address, mem_data});
        if (p && prev_pop) consec_pops++;
        if (done && error) both_flags++;
        prev_pop = p;
        if (p) total_pops++;
        @(posedge clk);
        if (p && fifo.size() > 0) void'(fifo.pop_front());
        @(negedge clk);
        drive();
        #1;
    endtask

    task automatic do_reset();
        stall_en = 1'b0;
        fifo.delete();
        rst = 1'b1;
        drive();
        #1;
        step();
        step();
        rst = 1'b0;
        obs_writes.delete();
        total_pops = 0;
    endtask

    // Frame-level prediction: find sync, read count, collect words, xor data.
    task automatic model();
        int i;
        int cnt;
        logic [7:0] x;
        exp_writes.delete();
        i = 0;
        while (i < frame.size() && frame[i] != SYNC) i++;
        i++;
        cnt = {frame[i], frame[i+1]};
        i += 2;
        if (cnt > MAXW) begin
            exp_outcome = 2;
            return;
        end
        x = 8'h00;
        for (int k = 0; k < cnt; k++) begin
            exp_writes.push_back({16'(BASE + k), frame[i], frame[i+1]});
            x = x ^ frame[i] ^ frame[i+1];
            i += 2;
        end
        exp_outcome = (frame[i] == x) ? 1 : 2;
    endtask

    task automatic run_frame(input string tag);
        int guard;
        int pops_before;
        model();
        obs_writes.delete();
        fifo = frame;
        drive();
        #1;
        guard = 0;
        while (fifo.size() > 0 && guard < 2000) begin
            step();
            guard++;
        end
        check({tag, "_drained"}, fifo.size(), 0);
        // Outcome flags must already be set right after the last pop edge.
        check({tag, "_done"},  done,     (exp_outcome == 1));
        check({tag, "_error"}, error,    (exp_outcome == 2));
        check({tag, "_hold"},  cpu_hold, (exp_outcome != 1));
        // Offer a fresh frame; a terminal state must ignore it.
        fifo = {SYNC, 8'h00, 8'h01, 8'h55, 8'h66, 8'h33};
        drive();
        #1;
        pops_before = total_pops;
        repeat (8) step();
        check({tag, "_post_pops"}, total_pops - pops_before, 0);
        check({tag, "_nwrites"}, obs_writes.size(), exp_writes.size());
        for (int k = 0; k < exp_writes.size() && k < obs_writes.size(); k++)
            check($sformatf("%s_write%0d", tag, k), obs_writes[k], exp_writes[k]);
        check({tag, "_consec_pop"}, consec_pops, 0);
        check({tag, "_done_and_error"}, both_flags, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int n;
        int cnt;
        logic [7:0] x;
        logic [7:0] b;

        @(negedge clk);
        drive();
        #1;

        // Reset values
        do_reset();
        check("rst_hold",  cpu_hold,     1);
        check("rst_done",  done,         0);
        check("rst_error", error,        0);
        check("rst_we",    mem_write_en, 0);
        check("rst_addr",  mem_address,  BASE);
        check("rst_data",  mem_data,     0);
        check("rst_pop",   rx_pop,       0);

        // Two-word frame, good checksum
        do_reset();
        frame = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        run_frame("good2");

        // Same frame, bad checksum
        do_reset();
        frame = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        run_frame("badcsum");

        // Leading garbage, zero-length frame
        do_reset();
        frame = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame("zero_len");

        // Oversized count
        do_reset();
        frame = {8'hA5, 8'h40, 8'h01};
        run_frame("too_long");

        // Boot timeout with no host
        do_reset();
        repeat (TO_CYCLES - 1) step();
        check("boot_to_early_done", done, 0);
        step();
        check("boot_to_done",  done,     1);
        check("boot_to_hold",  cpu_hold, 0);
        check("boot_to_error", error,    0);

        // Host goes silent after the length high byte
        do_reset();
        fifo = {8'hA5, 8'h00};
        drive();
        #1;
        guard = 0;
        while (fifo.size() > 0 && guard < 100) begin
            step();
            guard++;
        end
        check("silent_drained", fifo.size(), 0);
        repeat (TO_CYCLES - 1) step();
        check("silent_early_error", error, 0);
        step();
        check("silent_error", error,    1);
        check("silent_hold",  cpu_hold, 1);
        check("silent_done",  done,     0);

        // Reset in the middle of the second word
        do_reset();
        fifo = {8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h11};
        drive();
        #1;
        guard = 0;
        while (total_pops < 6 && guard < 100) begin
            step();
            guard++;
        end
        check("mid_pops", total_pops, 6);
        check("mid_nwrites", obs_writes.size(), 1);
        if (obs_writes.size() > 0) check("mid_write0", obs_writes[0], {16'h0000, 16'h1122});
        rst = 1'b1;
        fifo.delete();
        drive();
        #1;
        step();
        check("mid_rst_we",    mem_write_en, 0);
        check("mid_rst_addr",  mem_address,  BASE);
        check("mid_rst_data",  mem_data,     0);
        check("mid_rst_hold",  cpu_hold,     1);
        check("mid_rst_done",  done,         0);
        check("mid_rst_error", error,        0);
        rst = 1'b0;
        total_pops = 0;
        frame = {8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'h73};
        run_frame("after_mid_rst");

        // Randomized frames with FIFO stalls and occasional corrupt checksums
        for (int r = 0; r < 8; r++) begin
            do_reset();
            stall_en = 1'b1;
            frame.delete();
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h5A;
                frame.push_back(b);
            end
            cnt = $urandom_range(0, 6);
            frame.push_back(SYNC);
            frame.push_back(8'(cnt >> 8));
            frame.push_back(8'(cnt));
            x = 8'h00;
            for (int k = 0; k < 2 * cnt; k++) begin
                b = 8'($urandom_range(0, 255));
                frame.push_back(b);
                x = x ^ b;
            end
            if ($urandom_range(0, 3) == 0) x = x ^ (8'h01 << $urandom_range(0, 7));
            frame.push_back(x);
            run_frame($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
